vesa_pattern_checker: RTL and testbench

//  Receive-side checker for the VESA debug counter pattern (vs/de/data stream).

---
 rtl/vesa_pattern_checker.sv | 134 +++++++++++++
 tb/tb_vesa_pattern_checker.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/vesa_pattern_checker.sv
// Sink-side checker for the VESA debug counter ramp: per-beat data compare, line length and
// lines-per-frame measurement, per-frame pass/fail and sticky error statistics.
module vesa_pattern_checker #(
   parameter int unsigned          PIX_WIDTH = 16,
   parameter logic [PIX_WIDTH-1:0] SEED      = 16'hA500,
   parameter int unsigned          CNT_W     = 16
) (
   input  logic                 pix_clk,
   input  logic                 rstn,
   input  logic                 vs,
   input  logic                 de,
   input  logic [PIX_WIDTH-1:0] vesa_data,
   input  logic                 clr_err,
   output logic                 err_pulse,
   output logic                 err_flag,
   output logic [CNT_W-1:0]     err_cnt,
   output logic [PIX_WIDTH-1:0] first_err_exp,
   output logic [PIX_WIDTH-1:0] first_err_got,
   output logic [15:0]          line_len,
   output logic [15:0]          frame_lines,
   output logic                 len_err,
   output logic                 frame_done,
   output logic                 frame_pass
);

   localparam logic [PIX_WIDTH-1:0] PixOne = 1;
   localparam logic [CNT_W-1:0]     CntOne = 1;

   typedef enum logic [1:0] {StWaitVs, StVblank, StActive, StHblank} state_e;

   state_e               state_q, state_d;
   logic [PIX_WIDTH-1:0] exp_q;
   logic [15:0]          beat_cnt_q, line_cnt_q, ref_len_q;
   logic                 frame_err_q, frame_len_err_q;

   logic                 chk, first_beat, mism, line_end, frame_end, len_mis;
   logic [PIX_WIDTH-1:0] exp_val;
   logic [15:0]          beat_inc, line_inc;

   always_comb begin
      chk        = (state_q != StWaitVs) && de && !vs;
      first_beat = (state_q != StActive);
      exp_val    = first_beat ? SEED : exp_q;
      mism       = chk && (vesa_data != exp_val);
      line_end   = (state_q == StActive) && (vs || !de);
      frame_end  = vs && ((state_q == StActive) || (state_q == StHblank));
      // The first line of a frame only sets the reference length.
      len_mis    = line_end && (line_cnt_q != 16'd0) && (beat_cnt_q != ref_len_q);
      beat_inc   = (beat_cnt_q == 16'hFFFF) ? beat_cnt_q : beat_cnt_q + 16'd1;
      line_inc   = (line_cnt_q == 16'hFFFF) ? line_cnt_q : line_cnt_q + 16'd1;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StWaitVs: if (vs) state_d = StVblank;
         StVblank: if (!vs && de) state_d = StActive;
         StActive: begin
            if (vs)       state_d = StVblank;
            else if (!de) state_d = StHblank;
         end
         StHblank: begin
            if (vs)      state_d = StVblank;
            else if (de) state_d = StActive;
         end
         default: state_d = StWaitVs;
      endcase
   end

   always_ff @(posedge pix_clk) begin
      if (!rstn) begin
         state_q         <= StWaitVs;
         exp_q           <= SEED;
         beat_cnt_q      <= '0;
         line_cnt_q      <= '0;
         ref_len_q       <= '0;
         frame_err_q     <= 1'b0;
         frame_len_err_q <= 1'b0;
         err_pulse       <= 1'b0;
         err_flag        <= 1'b0;
         err_cnt         <= '0;
         first_err_exp   <= '0;
         first_err_got   <= '0;
         line_len        <= '0;
         frame_lines     <= '0;
         len_err         <= 1'b0;
         frame_done      <= 1'b0;
         frame_pass      <= 1'b0;
      end else begin
         state_q <= state_d;
         if (chk) begin
            exp_q      <= exp_val + PixOne;
            beat_cnt_q <= first_beat ? 16'd1 : beat_inc;
         end

         // A clear in the same cycle as a mismatch discards that mismatch entirely.
         err_pulse <= mism && !clr_err;
         if (clr_err) begin
            err_cnt       <= '0;
            err_flag      <= 1'b0;
            first_err_exp <= '0;
            first_err_got <= '0;
            len_err       <= 1'b0;
         end else begin
            if (mism) begin
               if (err_cnt != '1) err_cnt <= err_cnt + CntOne;
               err_flag <= 1'b1;
               if (!err_flag) begin
                  first_err_exp <= exp_val;
                  first_err_got <= vesa_data;
               end
            end
            if (len_mis) len_err <= 1'b1;
         end

         if (frame_end)                 frame_err_q <= 1'b0;
         else if (mism && !clr_err)     frame_err_q <= 1'b1;
         if (frame_end)                 frame_len_err_q <= 1'b0;
         else if (len_mis)              frame_len_err_q <= 1'b1;

         if (line_end) begin
            line_len <= beat_cnt_q;
            if (line_cnt_q == 16'd0) ref_len_q <= beat_cnt_q;
         end
         if (frame_end)     line_cnt_q <= '0;
         else if (line_end) line_cnt_q <= line_inc;

         frame_done <= frame_end;
         frame_pass <= frame_end && !(frame_err_q || frame_len_err_q || len_mis);
         if (frame_end) frame_lines <= line_end ? line_inc : line_cnt_q;
      end
   end

endmodule

// File: tb/tb_vesa_pattern_checker.sv
// Directed bench for vesa_pattern_checker: clean, corrupted, wrapping, short-line, pre-sync
// and mid-frame reset scenarios against hand-computed results.
module tb_vesa_pattern_checker;

   logic        pix_clk = 1'b0;
   logic        rstn, vs, de, clr_err;
   logic [15:0] vesa_data;

   logic        err_pulse, err_flag, len_err, frame_done, frame_pass;
   logic [15:0] err_cnt, first_err_exp, first_err_got, line_len, frame_lines;

   logic        err_pulse2, err_flag2, len_err2, frame_done2, frame_pass2;
   logic [15:0] err_cnt2, first_err_exp2, first_err_got2, line_len2, frame_lines2;

   int total = 0;
   int bad   = 0;
   int done_cnt = 0, pass_cnt = 0, pulse_cnt = 0;
   int d0, p0, e0;

   always #5 pix_clk = ~pix_clk;

   vesa_pattern_checker #(.PIX_WIDTH(16), .SEED(16'hA500), .CNT_W(16)) u_dut (
      .pix_clk(pix_clk), .rstn(rstn), .vs(vs), .de(de), .vesa_data(vesa_data),
      .clr_err(clr_err), .err_pulse(err_pulse), .err_flag(err_flag), .err_cnt(err_cnt),
      .first_err_exp(first_err_exp), .first_err_got(first_err_got), .line_len(line_len),
      .frame_lines(frame_lines), .len_err(len_err), .frame_done(frame_done),
      .frame_pass(frame_pass)
   );

   vesa_pattern_checker #(.PIX_WIDTH(16), .SEED(16'hFFFE), .CNT_W(16)) u_dut_wrap (
      .pix_clk(pix_clk), .rstn(rstn), .vs(vs), .de(de), .vesa_data(vesa_data),
      .clr_err(clr_err), .err_pulse(err_pulse2), .err_flag(err_flag2), .err_cnt(err_cnt2),
      .first_err_exp(first_err_exp2), .first_err_got(first_err_got2), .line_len(line_len2),
      .frame_lines(frame_lines2), .len_err(len_err2), .frame_done(frame_done2),
      .frame_pass(frame_pass2)
   );

   always @(negedge pix_clk) begin
      if (frame_done) done_cnt++;
      if (frame_done && frame_pass) pass_cnt++;
      if (err_pulse) pulse_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic beat(input logic v, input logic d, input logic [15:0] x, input logic c = 1'b0);
      vs = v; de = d; vesa_data = x; clr_err = c;
      @(posedge pix_clk);
      #1;
      clr_err = 1'b0;
   endtask

   task automatic vs_blank();
      repeat (3) beat(1'b1, 1'b0, 16'h0);
      beat(1'b0, 1'b0, 16'h0);
   endtask

   // Opens a frame with vsync then sends nlines lines; line 2 has length len2, others 8.
   task automatic send_frame(input int nlines, input int len2, input int cl, input int cp,
                             input logic [15:0] cv, input logic cclr);
      int len;
      repeat (3) beat(1'b1, 1'b0, 16'h0);
      for (int l = 0; l < nlines; l++) begin
         len = (l == 2) ? len2 : 8;
         for (int i = 0; i < len; i++) begin
            if (l == cl && i == cp) beat(1'b0, 1'b1, cv, cclr);
            else                    beat(1'b0, 1'b1, 16'hA500 + 16'(i));
         end
         repeat (2) beat(1'b0, 1'b0, 16'h0);
      end
   endtask

   initial begin
      rstn = 1'b0; vs = 1'b0; de = 1'b0; vesa_data = '0; clr_err = 1'b0;
      repeat (3) @(posedge pix_clk);
      #1;
      check("rst_err_cnt", err_cnt, 0);
      check("rst_err_flag", err_flag, 0);
      check("rst_frame_lines", frame_lines, 0);
      check("rst_line_len", line_len, 0);
      check("rst_first_exp", first_err_exp, 0);
      rstn = 1'b1;

      // Garbage before first vsync and de during vsync must be ignored.
      repeat (5) beat(1'b0, 1'b1, 16'hDEAD);
      repeat (3) beat(1'b1, 1'b1, 16'hBEEF);
      check("presync_err_cnt", err_cnt, 0);

      // Two clean frames.
      d0 = done_cnt; p0 = pass_cnt;
      send_frame(4, 8, -1, 0, 16'h0, 1'b0);
      send_frame(4, 8, -1, 0, 16'h0, 1'b0);
      vs_blank();
      check("clean_done", done_cnt - d0, 2);
      check("clean_pass", pass_cnt - p0, 2);
      check("clean_err_cnt", err_cnt, 0);
      check("clean_line_len", line_len, 8);
      check("clean_frame_lines", frame_lines, 4);

      // Corrupt line 1 pixel 3, then a clean frame, then a second corruption.
      d0 = done_cnt; p0 = pass_cnt; e0 = pulse_cnt;
      send_frame(4, 8, 1, 3, 16'h1234, 1'b0);
      vs_blank();
      check("corrupt_pulses", pulse_cnt - e0, 1);
      check("corrupt_err_cnt", err_cnt, 1);
      check("corrupt_err_flag", err_flag, 1);
      check("corrupt_first_exp", first_err_exp, 16'hA503);
      check("corrupt_first_got", first_err_got, 16'h1234);
      check("corrupt_done", done_cnt - d0, 1);
      check("corrupt_pass", pass_cnt - p0, 0);
      p0 = pass_cnt;
      send_frame(4, 8, -1, 0, 16'h0, 1'b0);
      vs_blank();
      check("recover_pass", pass_cnt - p0, 1);
      send_frame(4, 8, 3, 5, 16'h5555, 1'b0);
      vs_blank();
      check("second_err_cnt", err_cnt, 2);
      check("second_keeps_exp", first_err_exp, 16'hA503);
      check("second_keeps_got", first_err_got, 16'h1234);
      beat(1'b0, 1'b0, 16'h0, 1'b1);
      check("clr_err_cnt", err_cnt, 0);
      check("clr_err_flag", err_flag, 0);
      check("clr_first_exp", first_err_exp, 0);

      // Clear coincident with a mismatch drops the mismatch.
      e0 = pulse_cnt;
      send_frame(4, 8, 0, 2, 16'h0BAD, 1'b1);
      vs_blank();
      check("clr_collide_cnt", err_cnt, 0);
      check("clr_collide_flag", err_flag, 0);
      check("clr_collide_pulse", pulse_cnt - e0, 0);

      // Short third line.
      d0 = done_cnt; p0 = pass_cnt;
      send_frame(4, 7, -1, 0, 16'h0, 1'b0);
      vs_blank();
      check("len_err", len_err, 1);
      check("len_done", done_cnt - d0, 1);
      check("len_pass", pass_cnt - p0, 0);
      check("len_line_len", line_len, 8);
      check("len_frame_lines", frame_lines, 4);
      check("len_err_cnt", err_cnt, 0);
      beat(1'b0, 1'b0, 16'h0, 1'b1);
      check("len_clr", len_err, 0);

      // Vsync with no lines in between yields no frame_done.
      d0 = done_cnt;
      vs_blank();
      vs_blank();
      check("empty_frame_done", done_cnt - d0, 0);

      // Counter wrap on the FFFE-seeded instance.
      beat(1'b0, 1'b0, 16'h0, 1'b1);
      repeat (3) beat(1'b1, 1'b0, 16'h0);
      beat(1'b0, 1'b1, 16'hFFFE);
      beat(1'b0, 1'b1, 16'hFFFF);
      beat(1'b0, 1'b1, 16'h0000);
      beat(1'b0, 1'b1, 16'h0001);
      repeat (2) beat(1'b0, 1'b0, 16'h0);
      vs_blank();
      check("wrap_err_cnt", err_cnt2, 0);
      check("wrap_err_flag", err_flag2, 0);
      check("wrap_line_len", line_len2, 4);
      check("wrap_frame_lines", frame_lines2, 1);
      check("wrap_main_sees_err", err_cnt, 4);

      // Reset in the middle of a line.
      repeat (3) beat(1'b1, 1'b0, 16'h0);
      for (int i = 0; i < 4; i++) beat(1'b0, 1'b1, 16'hA500 + 16'(i));
      rstn = 1'b0;
      repeat (2) beat(1'b0, 1'b1, 16'hA504);
      check("midrst_err_cnt", err_cnt, 0);
      check("midrst_line_len", line_len, 0);
      check("midrst_frame_lines", frame_lines, 0);
      check("midrst_first_got", first_err_got, 0);
      rstn = 1'b1;
      for (int i = 4; i < 8; i++) beat(1'b0, 1'b1, 16'hA500 + 16'(i));
      d0 = done_cnt; p0 = pass_cnt;
      send_frame(4, 8, -1, 0, 16'h0, 1'b0);
      vs_blank();
      check("postrst_done", done_cnt - d0, 1);
      check("postrst_pass", pass_cnt - p0, 1);
      check("postrst_err_cnt", err_cnt, 0);
      check("postrst_frame_lines", frame_lines, 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
